// File: rtl/res_readout.sv
// res_readout: serial linear readout y = sum(Wout[i] * x[i]) over one
// accepted reservoir state vector, using a single shared MAC.
// Optional build macro RES_READOUT_SAT_EN: saturating accumulate instead of wrap.
module res_readout #(
  parameter int N     = 16,
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*W-1:0]          xstate,
  input  logic                    xstate_valid,
  output logic                    xstate_ready,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [W-1:0]            wr_data,
  output logic signed [ACC_W-1:0] y,
  output logic                    y_valid,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                  state, state_nxt;
  logic [N*W-1:0]          xsnap;
  logic signed [W-1:0]     wreg [N];
  logic signed [ACC_W-1:0] acc, acc_sum, prod_ext;
  logic signed [W-1:0]     w_cur, x_cur;
  logic signed [2*W-1:0]   prod;
  logic [AW-1:0]           idx;
  logic                    accept, last;

  assign w_cur    = wreg[idx];
  assign x_cur    = xsnap[idx*W +: W];
  assign prod     = w_cur * x_cur;
  assign prod_ext = ACC_W'(prod);
  assign last     = (idx == AW'(N-1));

`ifdef RES_READOUT_SAT_EN
  // Widen by one bit to detect overflow, then clamp to the signed range.
  logic signed [ACC_W:0] sum_w;
  assign sum_w = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
  always_comb begin
    acc_sum = sum_w[ACC_W-1:0];
    if (sum_w[ACC_W] != sum_w[ACC_W-1])
      acc_sum = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign acc_sum = acc + prod_ext;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt    = state;
    xstate_ready = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        xstate_ready = 1'b1;
        accept       = xstate_valid;
        if (xstate_valid) state_nxt = MAC;
      end
      MAC:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = !xstate_ready;

  // Datapath: snapshot on accept, one MAC per cycle, publish result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsnap   <= '0;
      acc     <= '0;
      idx     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (accept) begin
        xsnap <= xstate;
        acc   <= '0;
        idx   <= '0;
      end else if (state == MAC) begin
        acc <= acc_sum;
        idx <= last ? '0 : idx + 1'b1;
      end else if (state == DONE) begin
        y       <= acc;
        y_valid <= 1'b1;
      end
    end
  end

  // Weight register file; writes land in any state, out-of-range addresses dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) wreg[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < N)) begin
      wreg[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_res_readout.sv
// Directed bench for res_readout: reset, dot product, signed math, overflow,
// backpressure, live weight writes and reset abort.
module tb_res_readout;
  localparam int N = 16, W = 8, ACC_W = 16, AW = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N*W-1:0]          xstate = '0;
  logic                    xstate_valid = 1'b0;
  logic                    xstate_ready;
  logic                    wr_en = 1'b0;
  logic [AW-1:0]           wr_addr = '0;
  logic [W-1:0]            wr_data = '0;
  logic signed [ACC_W-1:0] y;
  logic                    y_valid;
  logic                    busy;

  int total = 0;
  int bad   = 0;

  res_readout #(.N(N), .W(W), .ACC_W(ACC_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .xstate(xstate), .xstate_valid(xstate_valid),
    .xstate_ready(xstate_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .y(y), .y_valid(y_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_w(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = W'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wr_all(input int d);
    for (int i = 0; i < N; i++) wr_w(i, d);
  endtask

  // Present one vector, then scramble the input bus to prove the snapshot,
  // and check latency, result and single-cycle pulse.
  task automatic run(input string tag, input logic [N*W-1:0] xv, input longint exp);
    int lat;
    lat = 0;
    xstate = xv; xstate_valid = 1'b1;
    chk({tag, ".ready"}, xstate_ready, 1);
    @(posedge clk); #1;
    xstate_valid = 1'b0; xstate = ~xv;
    chk({tag, ".busy"}, busy, 1);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (y_valid) begin lat = c; break; end
    end
    chk({tag, ".lat"}, lat, 17);
    chk({tag, ".y"}, $signed(y), exp);
    chk({tag, ".rdy_with_yv"}, xstate_ready, 1);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, y_valid, 0);
  endtask

  logic [N*W-1:0] xv;
  int acc_start [$];
  longint exp_q [$];
  int yv_cnt, nacc;
  longint e;

  initial begin
    // Reset state.
    #1;
    chk("rst.y", $signed(y), 0);
    chk("rst.y_valid", y_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.ready", xstate_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic dot product: w=1, x[i]=i -> 120.
    wr_all(1);
    for (int i = 0; i < N; i++) xv[i*W +: W] = W'(i);
    run("basic", xv, 120);

    // Reset mid-MAC: abort, no pulse, weights cleared.
    xstate = xv; xstate_valid = 1'b1;
    @(posedge clk); #1;
    xstate_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort.ready", xstate_ready, 1);
    chk("abort.y", $signed(y), 0);
    yv_cnt = 0;
    repeat (2) begin @(posedge clk); #1; if (y_valid) yv_cnt++; end
    rst = 1'b0;
    chk("abort.ready_after", xstate_ready, 1);
    repeat (25) begin @(posedge clk); #1; if (y_valid) yv_cnt++; end
    chk("abort.no_pulse", yv_cnt, 0);
    run("abort.cleared_w", xv, 0);

    // Signed: -3*5 + -128*-1 = 113.
    wr_all(0);
    wr_w(0, -3); wr_w(1, -128);
    xv = '0; xv[0 +: W] = 8'd5; xv[W +: W] = 8'hFF;
    run("signed", xv, 113);

    // Overflow: 16 * 16384 = 262144.
    wr_all(-128);
    for (int i = 0; i < N; i++) xv[i*W +: W] = 8'h80;
`ifdef RES_READOUT_SAT_EN
    run("overflow", xv, 32767);
`else
    run("overflow", xv, 0);
`endif

    // Live writes: w15 1->2 while idx=3, w4 1->9 on the edge that consumes idx 4
    // (old value must be used). Expected 15 + 2 = 17.
    wr_all(1);
    for (int i = 0; i < N; i++) xv[i*W +: W] = 8'd1;
    xstate = xv; xstate_valid = 1'b1;
    @(posedge clk); #1;
    xstate_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'd2;
    @(posedge clk); #1;
    wr_addr = 4'd4; wr_data = 8'd9;
    @(posedge clk); #1;
    wr_en = 1'b0;
    nacc = 0;
    for (int c = 0; c < 30; c++) begin
      if (y_valid) begin nacc = 1; break; end
      @(posedge clk); #1;
    end
    chk("live.seen", nacc, 1);
    chk("live.y", $signed(y), 17);
    @(posedge clk); #1;

    // Backpressure: valid held high, data changes every cycle.
    wr_all(1);
    yv_cnt = 0;
    xstate_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      e = 0;
      for (int i = 0; i < N; i++) begin
        xv[i*W +: W] = W'((c * 7 + i * 3) % 50 - 25);
        e += (c * 7 + i * 3) % 50 - 25;
      end
      xstate = xv;
      chk("bp.busy_inv", busy, !xstate_ready);
      if (xstate_ready) begin acc_start.push_back(c); exp_q.push_back(e); end
      @(posedge clk); #1;
      if (y_valid) begin
        yv_cnt++;
        if (exp_q.size() > 0) chk("bp.y", $signed(y), exp_q.pop_front());
        else chk("bp.spurious", 1, 0);
      end
    end
    xstate_valid = 1'b0;
    chk("bp.accepts", acc_start.size(), 3);
    chk("bp.results", yv_cnt, 2);
    if (acc_start.size() >= 3) begin
      chk("bp.gap1", acc_start[1] - acc_start[0], 18);
      chk("bp.gap2", acc_start[2] - acc_start[1], 18);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
